fetch_byte_aligner: RTL and testbench

Controller that sequences a 32-byte right-rotate byte shifter to turn a stream of 16-byte fetch lines into a byte-aligned 16-byte window. It sits between the instruction-fetch line source and the decoder. It holds two lines in a 32-byte circular buffer and keeps a byte read pointer. That pointer drives the rotate amount of an internal `shift_right_rotate` instance (WIDTH=32, N=8), so window byte 0 is always the oldest unconsumed byte. The decoder consumes 1-15 bytes per cycle. Flush with a start offset supports redirects.

---
 rtl/fetch_byte_aligner_if.sv | 28 ++
 rtl/fetch_byte_aligner.sv | 104 ++++++++++
 tb/tb_fetch_byte_aligner.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/fetch_byte_aligner_if.sv
// Fetch-line / decoder-window bundle for fetch_byte_aligner.
// master = fetch source + decoder side, slave = aligner.
interface fetch_byte_aligner_if #(
  parameter int LINE_BYTES = 16
);
  localparam int OW = $clog2(LINE_BYTES);
  localparam int CW = $clog2(2*LINE_BYTES) + 1;

  logic                    flush;
  logic [OW-1:0]           flush_off;
  logic                    line_valid;
  logic                    line_ready;
  logic [LINE_BYTES*8-1:0] line_data;
  logic                    win_valid;
  logic [LINE_BYTES*8-1:0] win_data;
  logic [CW-1:0]           win_cnt;
  logic                    consume_valid;
  logic [OW-1:0]           consume_len;

  modport master (
    output flush, flush_off, line_valid, line_data, consume_valid, consume_len,
    input  line_ready, win_valid, win_data, win_cnt
  );
  modport slave (
    input  flush, flush_off, line_valid, line_data, consume_valid, consume_len,
    output line_ready, win_valid, win_data, win_cnt
  );
endinterface

// File: rtl/fetch_byte_aligner.sv
// Two-line circular byte buffer feeding a byte rotator so the decoder always
// sees the oldest unconsumed byte at window byte 0.

module shift_right_rotate #(
  parameter int WIDTH     = 32,
  parameter int N         = 8,
  parameter int OUT_LANES = WIDTH,
  parameter int AW        = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0][N-1:0]     din,
  input  logic [AW-1:0]               amt,
  output logic [OUT_LANES-1:0][N-1:0] dout
);
  // WIDTH is a power of two, so the AW-bit add wraps modulo WIDTH.
  for (genvar i = 0; i < OUT_LANES; i++) begin : g_lane
    logic [AW-1:0] idx;
    assign idx     = AW'(i) + amt;
    assign dout[i] = din[idx];
  end
endmodule

module fetch_byte_aligner #(
  parameter int LINE_BYTES = 16,
  parameter int PTR_W      = 5
) (
  input logic                   clk,
  input logic                   rst_n,
  fetch_byte_aligner_if.slave   bus
);
  localparam int OW = $clog2(LINE_BYTES);
  localparam int CW = $clog2(2*LINE_BYTES) + 1;

  logic [1:0][LINE_BYTES-1:0][7:0] buf_q;
  logic [1:0]                      half_v;
  logic                            wr_half;
  logic [PTR_W-1:0]                ptr;
  logic [CW-1:0]                   cnt;
  logic                            drop_pend;
  logic [OW-1:0]                   drop_amt;

  logic                            acc, cons;
  logic [PTR_W-1:0]                ptr_n;
  logic [CW-1:0]                   add_amt, sub_amt;
  logic [1:0]                      half_v_n;
  logic [2*LINE_BYTES-1:0][7:0]    buf_flat;
  logic [LINE_BYTES-1:0][7:0]      win_b;

  assign bus.line_ready = !half_v[wr_half];
  assign bus.win_valid  = (cnt >= CW'(LINE_BYTES));
  assign bus.win_cnt    = cnt;
  assign bus.win_data   = win_b;

  assign acc   = bus.line_valid && bus.line_ready && !bus.flush;
  assign cons  = bus.consume_valid && bus.win_valid && (bus.consume_len != '0) && !bus.flush;
  assign ptr_n = ptr + PTR_W'(bus.consume_len);

  assign add_amt = acc  ? (CW'(LINE_BYTES) - (drop_pend ? CW'(drop_amt) : '0)) : '0;
  assign sub_amt = cons ? CW'(bus.consume_len) : '0;

  // Accept targets a free half and consume only frees a valid one, so the
  // set and clear never touch the same bit.
  always_comb begin
    half_v_n = half_v;
    if (acc) half_v_n[wr_half] = 1'b1;
    if (cons && (ptr_n[PTR_W-1] != ptr[PTR_W-1])) half_v_n[ptr[PTR_W-1]] = 1'b0;
  end

  assign buf_flat = buf_q;

  shift_right_rotate #(.WIDTH(2*LINE_BYTES), .N(8), .OUT_LANES(LINE_BYTES)) u_rot (
    .din  (buf_flat),
    .amt  (ptr),
    .dout (win_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q     <= '0;
      half_v    <= '0;
      wr_half   <= 1'b0;
      ptr       <= '0;
      cnt       <= '0;
      drop_pend <= 1'b0;
      drop_amt  <= '0;
    end else if (bus.flush) begin
      // Buffer contents are left stale; cnt/half_v gate what is visible.
      half_v    <= '0;
      wr_half   <= 1'b0;
      cnt       <= '0;
      ptr       <= PTR_W'(bus.flush_off);
      drop_pend <= 1'b1;
      drop_amt  <= bus.flush_off;
    end else begin
      if (acc) begin
        buf_q[wr_half] <= bus.line_data;
        wr_half        <= !wr_half;
        drop_pend      <= 1'b0;
      end
      if (cons) ptr <= ptr_n;
      half_v <= half_v_n;
      cnt    <= cnt + add_amt - sub_amt;
    end
  end
endmodule

// File: tb/tb_fetch_byte_aligner.sv
// Directed bench for fetch_byte_aligner: per-cycle vector table plus reset corners.
module tb_fetch_byte_aligner;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  fetch_byte_aligner_if #(.LINE_BYTES(16)) bus ();

  fetch_byte_aligner #(.LINE_BYTES(16), .PTR_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       fl;
    logic [3:0] off;
    logic       lv;
    logic [7:0] lbase;
    logic       cv;
    logic [3:0] clen;
    logic [5:0] cnt;
    logic       rdy;
    logic       vld;
    logic [7:0] b0;
    logic [7:0] b15;
  } vec_t;

  localparam int NV = 17;
  vec_t tv [NV];

  function automatic logic [127:0] mkline(input logic [7:0] base);
    logic [127:0] l;
    for (int k = 0; k < 16; k++) l[8*k +: 8] = base + 8'(k);
    return l;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Structural invariants sampled every cycle away from the clock edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("inv cnt<=32", {127'd0, bus.win_cnt <= 6'd32}, 128'd1);
      chk("inv valid==cnt>=16", {127'd0, bus.win_valid}, {127'd0, bus.win_cnt >= 6'd16});
    end
  end

  task automatic idle_inputs();
    bus.flush         = 1'b0;
    bus.flush_off     = 4'd0;
    bus.line_valid    = 1'b0;
    bus.line_data     = '0;
    bus.consume_valid = 1'b0;
    bus.consume_len   = 4'd0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " line_ready"}, {127'd0, bus.line_ready}, 128'd1);
    chk({tag, " win_valid"},  {127'd0, bus.win_valid},  128'd0);
    chk({tag, " win_cnt"},    {122'd0, bus.win_cnt},    128'd0);
    chk({tag, " win_data"},   bus.win_data,             128'd0);
  endtask

  initial begin
    //        fl off lv lbase   cv clen   cnt rdy vld b0     b15
    tv[0]  = '{0, 0, 1, 8'h00, 0, 0,  16, 1, 1, 8'h00, 8'h0F}; // L0
    tv[1]  = '{0, 0, 1, 8'h10, 0, 0,  32, 0, 1, 8'h00, 8'h0F}; // L1, buffer full
    tv[2]  = '{0, 0, 1, 8'h20, 0, 0,  32, 0, 1, 8'h00, 8'h0F}; // offered while not ready
    tv[3]  = '{0, 0, 0, 8'h00, 1, 7,  25, 0, 1, 8'h07, 8'h16};
    tv[4]  = '{0, 0, 0, 8'h00, 1, 9,  16, 1, 1, 8'h10, 8'h1F}; // crosses into half 1
    tv[5]  = '{0, 0, 1, 8'h20, 1, 12, 20, 0, 1, 8'h1C, 8'h2B}; // accept+consume, window wraps
    tv[6]  = '{0, 0, 1, 8'h40, 1, 6,  14, 1, 0, 8'h22, 8'h11}; // wrap 31->0, freed half not yet writable
    tv[7]  = '{0, 0, 1, 8'h30, 0, 0,  30, 0, 1, 8'h22, 8'h31};
    tv[8]  = '{0, 0, 0, 8'h00, 1, 0,  30, 0, 1, 8'h22, 8'h31}; // len 0 ignored
    tv[9]  = '{0, 0, 0, 8'h00, 1, 15, 15, 1, 0, 8'h31, 8'h20};
    tv[10] = '{0, 0, 0, 8'h00, 1, 3,  15, 1, 0, 8'h31, 8'h20}; // consume while !win_valid ignored
    tv[11] = '{1, 5, 1, 8'h90, 1, 3,  0,  1, 0, 8'h25, 8'h34}; // flush; line and consume dropped
    tv[12] = '{0, 0, 1, 8'hA0, 0, 0,  11, 1, 0, 8'hA5, 8'h34};
    tv[13] = '{0, 0, 1, 8'hB0, 0, 0,  27, 0, 1, 8'hA5, 8'hB4};
    tv[14] = '{0, 0, 0, 8'h00, 1, 11, 16, 1, 1, 8'hB0, 8'hBF};
    tv[15] = '{0, 0, 1, 8'hC0, 1, 15, 17, 0, 1, 8'hBF, 8'hCE}; // ptr 31, window wraps
    tv[16] = '{0, 0, 0, 8'h00, 1, 2,  15, 1, 0, 8'hC1, 8'hB0}; // ptr 31->1 frees half 1

    idle_inputs();
    rst_n = 1'b0;
    #12;
    chk_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      bus.flush         = tv[i].fl;
      bus.flush_off     = tv[i].off;
      bus.line_valid    = tv[i].lv;
      bus.line_data     = mkline(tv[i].lbase);
      bus.consume_valid = tv[i].cv;
      bus.consume_len   = tv[i].clen;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d win_cnt", i),   {122'd0, bus.win_cnt},    {122'd0, tv[i].cnt});
      chk($sformatf("v%0d line_ready", i), {127'd0, bus.line_ready}, {127'd0, tv[i].rdy});
      chk($sformatf("v%0d win_valid", i),  {127'd0, bus.win_valid},  {127'd0, tv[i].vld});
      chk($sformatf("v%0d byte0", i),      {120'd0, bus.win_data[7:0]},     {120'd0, tv[i].b0});
      chk($sformatf("v%0d byte15", i),     {120'd0, bus.win_data[127:120]}, {120'd0, tv[i].b15});
      if (i == 1) chk("fill window", bus.win_data, mkline(8'h00));
      if (i == 14) chk("post-flush window", bus.win_data, mkline(8'hB0));
    end

    // Reset asserted mid-stream between clock edges clears outputs at once.
    @(negedge clk);
    idle_inputs();
    bus.line_valid = 1'b1;
    bus.line_data  = mkline(8'hD0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    @(posedge clk);
    #1;
    chk_reset_outputs("midrst held");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("after rst accept cnt", {122'd0, bus.win_cnt}, 128'd16);
    chk("after rst byte0", {120'd0, bus.win_data[7:0]}, 128'hD0);
    idle_inputs();
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
